// File: rtl/ps2_message_composer_if.sv
// Keystroke-in / message-out bundle between the PS/2 front end, the composer
// and the gpio_protocol sender.
interface ps2_message_composer_if #(
  parameter int unsigned MAX_CHARS = 16
);
  localparam int unsigned MSG_W = 8 * MAX_CHARS;
  localparam int unsigned LEN_W = $clog2(MAX_CHARS + 1);

  logic             enable;
  logic             clear;
  logic             key_valid;
  logic [7:0]       key_ascii;
  logic             send_ready;
  logic [MSG_W-1:0] message;
  logic [LEN_W-1:0] length;
  logic             send_valid;
  logic             sent;
  logic             timeout;
  logic             overflow;

  modport master (
    output enable, clear, key_valid, key_ascii, send_ready,
    input  message, length, send_valid, sent, timeout, overflow
  );

  modport slave (
    input  enable, clear, key_valid, key_ascii, send_ready,
    output message, length, send_valid, sent, timeout, overflow
  );
endinterface

// File: rtl/ps2_message_composer.sv
// Line editor: collects ASCII keystrokes into a padded 16-char buffer, supports
// backspace, and hands the buffer to the sender on Enter via valid/ready.
module ps2_message_composer #(
  parameter int unsigned MAX_CHARS    = 16,
  parameter logic [7:0]  PAD_CHAR     = 8'h20,
  parameter int unsigned SEND_TIMEOUT = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                   clock,
  input  logic                   RESETN,
  ps2_message_composer_if.slave  bus
);
  localparam int unsigned MSG_W = 8 * MAX_CHARS;
  localparam int unsigned LEN_W = $clog2(MAX_CHARS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_CHARS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEND_TIMEOUT - 1);
  localparam logic [MSG_W-1:0] PAD_MSG  = {MAX_CHARS{PAD_CHAR}};

  typedef enum logic {EDIT, SEND} state_t;

  state_t           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             send_valid_q, send_valid_d;
  logic             sent_q, sent_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             key_valid_q;
  logic             key_armed_q;
  logic             accept;
  logic             printable;

  // key_armed_q stays low until key_valid is seen low, so a key held through
  // reset release does not look like a fresh rising edge.
  assign accept    = bus.key_valid & ~key_valid_q & key_armed_q & bus.enable & (state_q == EDIT);
  assign printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);

  always_ff @(posedge clock or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= EDIT;
      msg_q        <= PAD_MSG;
      len_q        <= '0;
      cnt_q        <= '0;
      send_valid_q <= 1'b0;
      sent_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      key_valid_q  <= 1'b0;
      key_armed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      send_valid_q <= send_valid_d;
      sent_q       <= sent_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      key_valid_q  <= bus.key_valid;
      key_armed_q  <= key_armed_q | ~bus.key_valid;
    end
  end

  // Next-state: clear dominates, then per-state editing / send handshake.
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sent_d     = 1'b0;
    timeout_d  = 1'b0;
    overflow_d = 1'b0;

    if (bus.clear) begin
      state_d = EDIT;
      msg_d   = PAD_MSG;
      len_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        EDIT: begin
          if (accept) begin
            if (printable) begin
              if (len_q < LEN_MAX) begin
                for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                  if (LEN_W'(i) == len_q) msg_d[8*i +: 8] = bus.key_ascii;
                end
                len_d = len_q + 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end else if ((bus.key_ascii == 8'h08) && (len_q != '0)) begin
              for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                if (LEN_W'(i) == (len_q - 1'b1)) msg_d[8*i +: 8] = PAD_CHAR;
              end
              len_d = len_q - 1'b1;
            end else if ((bus.key_ascii == 8'h0D) && (len_q != '0)) begin
              state_d = SEND;
              cnt_d   = '0;
            end
          end
        end
        SEND: begin
          if (bus.send_ready) begin
            sent_d  = 1'b1;
            msg_d   = PAD_MSG;
            len_d   = '0;
            state_d = EDIT;
          end else if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = EDIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = EDIT;
      endcase
    end

    send_valid_d = (state_d == SEND);
  end

  assign bus.message    = msg_q;
  assign bus.length     = len_q;
  assign bus.send_valid = send_valid_q;
  assign bus.sent       = sent_q;
  assign bus.timeout    = timeout_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_message_composer.sv
// Directed bench for ps2_message_composer: typing, overflow, backspace, send
// handshake, send timeout, reset and clear behaviour.
module tb_ps2_message_composer;
  localparam logic [127:0] PAD  = {16{8'h20}};
  localparam logic [127:0] ALLA = {16{8'h41}};

  logic clock;
  logic RESETN;
  int   errors = 0;
  int   checks = 0;
  int   ovf_cnt = 0;
  int   sent_cnt = 0;
  int   to_cnt = 0;
  int   sv_cnt = 0;

  ps2_message_composer_if #(.MAX_CHARS(16)) bus ();

  ps2_message_composer #(
    .MAX_CHARS(16), .PAD_CHAR(8'h20), .SEND_TIMEOUT(8), .CNT_W(26)
  ) u_dut (
    .clock (clock),
    .RESETN(RESETN),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse / level occupancy counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.overflow)   ovf_cnt++;
    if (bus.sent)       sent_cnt++;
    if (bus.timeout)    to_cnt++;
    if (bus.send_valid) sv_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [7:0] c);
    bus.key_ascii = c;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  logic [127:0] exp_msg;
  int           snap;

  initial begin
    RESETN         = 1'b0;
    bus.enable     = 1'b1;
    bus.clear      = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_ascii  = 8'h00;
    bus.send_ready = 1'b0;
    tick();
    tick();
    check("rst_len", 128'(bus.length), 128'd0);
    check("rst_msg", bus.message, PAD);
    check("rst_flags", 128'({bus.send_valid, bus.sent, bus.timeout, bus.overflow}), 128'd0);
    RESETN = 1'b1;
    tick();

    // Basic typing
    press(8'h48);
    press(8'h69);
    exp_msg = PAD;
    exp_msg[15:0] = 16'h6948;
    check("hi_len", 128'(bus.length), 128'd2);
    check("hi_msg", bus.message, exp_msg);

    // enable low, and a key held across enable rising
    bus.enable = 1'b0;
    press(8'h58);
    check("dis_len", 128'(bus.length), 128'd2);
    bus.key_ascii = 8'h59;
    bus.key_valid = 1'b1;
    tick();
    bus.enable = 1'b1;
    tick();
    tick();
    check("held_en_len", 128'(bus.length), 128'd2);
    bus.key_valid = 1'b0;
    tick();

    // Fill and overflow
    do_clear();
    for (int i = 0; i < 16; i++) press(8'h41);
    check("full_len", 128'(bus.length), 128'd16);
    check("full_msg", bus.message, ALLA);
    check("full_no_ovf", 128'(ovf_cnt), 128'd0);
    bus.key_ascii = 8'h41;
    bus.key_valid = 1'b1;
    tick();
    check("ovf_pulse", 128'(bus.overflow), 128'd1);
    bus.key_valid = 1'b0;
    tick();
    check("ovf_low", 128'(bus.overflow), 128'd0);
    check("ovf_count", 128'(ovf_cnt), 128'd1);
    check("ovf_len", 128'(bus.length), 128'd16);
    check("ovf_msg", bus.message, ALLA);

    // Backspace and underflow guard
    do_clear();
    press(8'h48);
    press(8'h69);
    press(8'h08);
    exp_msg = PAD;
    exp_msg[7:0] = 8'h48;
    check("bs_len", 128'(bus.length), 128'd1);
    check("bs_msg", bus.message, exp_msg);
    for (int i = 0; i < 3; i++) press(8'h08);
    check("bs0_len", 128'(bus.length), 128'd0);
    check("bs0_msg", bus.message, PAD);

    // Enter with send_ready after three send_valid cycles
    do_clear();
    press(8'h4F);
    press(8'h4B);
    check("ok_msg", 128'(bus.message[15:0]), 128'h4B4F);
    snap = sv_cnt;
    bus.key_ascii = 8'h0D;
    bus.key_valid = 1'b1;
    tick();
    check("send_sv1", 128'(bus.send_valid), 128'd1);
    bus.key_valid = 1'b0;
    tick();
    bus.key_ascii = 8'h5A;
    bus.key_valid = 1'b1;
    tick();
    check("send_sv3", 128'(bus.send_valid), 128'd1);
    check("send_frozen", 128'({bus.length, bus.message[15:0]}), 128'({5'd2, 16'h4B4F}));
    bus.key_valid  = 1'b0;
    bus.send_ready = 1'b1;
    snap = sent_cnt + 0 * snap + (sv_cnt - snap) * 0;
    tick();
    bus.send_ready = 1'b0;
    check("sent_pulse", 128'({bus.sent, bus.send_valid, bus.timeout}), 128'b100);
    check("sent_len", 128'(bus.length), 128'd0);
    check("sent_msg", bus.message, PAD);
    tick();
    check("sent_low", 128'(bus.sent), 128'd0);
    check("sent_count", 128'(sent_cnt - snap), 128'd1);

    // Timeout after 8 SEND cycles
    do_clear();
    press(8'h4F);
    press(8'h4B);
    snap = sv_cnt;
    bus.key_ascii = 8'h0D;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait", 128'({bus.send_valid, bus.timeout}), 128'b10);
    end
    tick();
    check("to_pulse", 128'({bus.send_valid, bus.timeout, bus.sent}), 128'b010);
    check("to_kept", 128'({bus.length, bus.message[15:0]}), 128'({5'd2, 16'h4B4F}));
    check("to_sv_cycles", 128'(sv_cnt - snap), 128'd8);
    tick();
    check("to_low", 128'(bus.timeout), 128'd0);

    // send_ready on the final SEND cycle beats the timeout
    snap = to_cnt;
    bus.key_ascii = 8'h0D;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.send_ready = 1'b1;
    tick();
    bus.send_ready = 1'b0;
    check("race_flags", 128'({bus.sent, bus.timeout, bus.send_valid}), 128'b100);
    check("race_len", 128'(bus.length), 128'd0);
    tick();
    check("race_no_to", 128'(to_cnt - snap), 128'd0);

    // Async reset mid-SEND, key held across reset release
    do_clear();
    press(8'h4F);
    press(8'h4B);
    bus.key_ascii = 8'h0D;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
    check("pre_rst_sv", 128'(bus.send_valid), 128'd1);
    #2;
    RESETN = 1'b0;
    #1;
    check("rst_sv", 128'(bus.send_valid), 128'd0);
    check("rst_buf", bus.message, PAD);
    bus.key_ascii = 8'h51;
    bus.key_valid = 1'b1;
    @(negedge clock);
    RESETN = 1'b1;
    tick();
    tick();
    check("held_rst_len", 128'(bus.length), 128'd0);
    bus.key_valid = 1'b0;
    tick();
    press(8'h51);
    check("post_rst_len", 128'(bus.length), 128'd1);

    // clear and Enter in the same cycle
    bus.clear     = 1'b1;
    bus.key_ascii = 8'h0D;
    bus.key_valid = 1'b1;
    tick();
    bus.clear     = 1'b0;
    bus.key_valid = 1'b0;
    check("clr_enter", 128'({bus.send_valid, bus.length}), 128'd0);
    tick();
    check("clr_no_send", 128'(bus.send_valid), 128'd0);
    check("clr_msg", bus.message, PAD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
